// File: rtl/uart_ip_pkg.sv
// Shared definitions for the UART IP memory-mapped slave: arbiter states,
// requester indices and the command codes used by the UART command FSM.
package uart_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic RQ_UART = 1'b0;
  localparam logic RQ_HOST = 1'b1;

  localparam logic [7:0] READ      = 8'h00;
  localparam logic [7:0] WRITE     = 8'h01;
  localparam logic [7:0] CONFIGURE = 8'h02;
  localparam logic [7:0] STATUS    = 8'h03;

endpackage

// File: rtl/uart_ip_rr_pick.sv
// Combinational 2-way round-robin picker: on contention the requester that
// was not granted last wins.
module uart_ip_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       pick_valid,
  output logic       pick_idx
);

  always_comb begin
    pick_valid = |req;
    pick_idx   = req[1];
    if (req == 2'b11) pick_idx = ~last_gnt;
  end

endmodule

// File: rtl/uart_ip_mem_arbiter.sv
// Shares the UART IP memory port between the command FSM (requester 0) and a
// host/debug master (requester 1): round-robin, one transaction at a time.
module uart_ip_mem_arbiter
  import uart_ip_pkg::*;
#(
  parameter int unsigned NUM_BYTES_DATA    = 4,
  parameter int unsigned NUM_BYTES_ADDRESS = 1,
  parameter int unsigned TIMEOUT_CYCLES    = 255,
  localparam int unsigned DW = NUM_BYTES_DATA * 8,
  localparam int unsigned AW = NUM_BYTES_ADDRESS * 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          rq0_req,
  input  logic          rq0_we,
  input  logic [AW-1:0] rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  input  logic          rq1_req,
  input  logic          rq1_we,
  input  logic [AW-1:0] rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rq0_gnt,
  output logic          rq0_done,
  output logic [DW-1:0] rq0_rdata,
  output logic          rq0_err,
  output logic          rq1_gnt,
  output logic          rq1_done,
  output logic [DW-1:0] rq1_rdata,
  output logic          rq1_err,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic          busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          last_gnt;
  logic          idx;
  logic          we_r;
  logic          pick_valid;
  logic          pick_idx;

  uart_ip_rr_pick u_pick (
    .req        ({rq1_req, rq0_req}),
    .last_gnt   (last_gnt),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      idx       <= RQ_UART;
      we_r      <= 1'b0;
      rq0_gnt   <= 1'b0;
      rq1_gnt   <= 1'b0;
      rq0_done  <= 1'b0;
      rq1_done  <= 1'b0;
      rq0_rdata <= '0;
      rq1_rdata <= '0;
      rq0_err   <= 1'b0;
      rq1_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      rq0_gnt  <= 1'b0;
      rq1_gnt  <= 1'b0;
      rq0_done <= 1'b0;
      rq1_done <= 1'b0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx      <= pick_idx;
            last_gnt <= pick_idx;
            busy     <= 1'b1;
            state    <= ISSUE;
            if (pick_idx == RQ_HOST) begin
              we_r      <= rq1_we;
              mem_addr  <= rq1_addr;
              mem_wdata <= rq1_wdata;
              rq1_gnt   <= 1'b1;
            end else begin
              we_r      <= rq0_we;
              mem_addr  <= rq0_addr;
              mem_wdata <= rq0_wdata;
              rq0_gnt   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (we_r) begin
            mem_we <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
            if (idx == RQ_HOST) begin
              rq1_done <= 1'b1;
              rq1_err  <= 1'b0;
            end else begin
              rq0_done <= 1'b1;
              rq0_err  <= 1'b0;
            end
          end else begin
            mem_re <= 1'b1;
            cnt    <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          // mem_rdy is checked before the timeout so late-but-in-time data wins
          if (mem_rdy || cnt == CNT_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (idx == RQ_HOST) begin
              rq1_done  <= 1'b1;
              rq1_err   <= ~mem_rdy;
              rq1_rdata <= mem_rdy ? mem_rdata : '0;
            end else begin
              rq0_done  <= 1'b1;
              rq0_err   <= ~mem_rdy;
              rq0_rdata <= mem_rdy ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ip_mem_arbiter.sv
// Directed bench for uart_ip_mem_arbiter, built with a 4-cycle read timeout.
module tb_uart_ip_mem_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        rq0_req, rq0_we, rq1_req, rq1_we;
  logic [7:0]  rq0_addr, rq1_addr, mem_addr;
  logic [31:0] rq0_wdata, rq1_wdata, rq0_rdata, rq1_rdata;
  logic        rq0_gnt, rq0_done, rq0_err, rq1_gnt, rq1_done, rq1_err;
  logic        mem_we, mem_re, mem_rdy, busy;
  logic [31:0] mem_wdata, mem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  uart_ip_mem_arbiter #(
    .NUM_BYTES_DATA    (4),
    .NUM_BYTES_ADDRESS (1),
    .TIMEOUT_CYCLES    (4)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rq0_req   (rq0_req),
    .rq0_we    (rq0_we),
    .rq0_addr  (rq0_addr),
    .rq0_wdata (rq0_wdata),
    .rq1_req   (rq1_req),
    .rq1_we    (rq1_we),
    .rq1_addr  (rq1_addr),
    .rq1_wdata (rq1_wdata),
    .rq0_gnt   (rq0_gnt),
    .rq0_done  (rq0_done),
    .rq0_rdata (rq0_rdata),
    .rq0_err   (rq0_err),
    .rq1_gnt   (rq1_gnt),
    .rq1_done  (rq1_done),
    .rq1_rdata (rq1_rdata),
    .rq1_err   (rq1_err),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned n;
  int unsigned ord [4];
  int unsigned ord_exp [4] = '{0, 1, 0, 1};
  logic re0, re1, back2back;

  initial begin
    arst_n = 1'b0;
    rq0_req = 0; rq0_we = 0; rq0_addr = '0; rq0_wdata = '0;
    rq1_req = 0; rq1_we = 0; rq1_addr = '0; rq1_wdata = '0;
    mem_rdy = 0; mem_rdata = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_strobes", {26'd0, rq0_gnt, rq1_gnt, rq0_done, rq1_done, mem_we, mem_re}, 0);
    check("rst_addr", {24'd0, mem_addr}, 0);
    step(); step();
    arst_n = 1'b1;
    step();

    // rq0 write 0x12 <- 0xDEADBEEF
    rq0_req = 1; rq0_we = 1; rq0_addr = 8'h12; rq0_wdata = 32'hDEADBEEF;
    step();
    check("wr_gnt0", {30'd0, rq0_gnt, rq1_gnt}, 32'b10);
    check("wr_busy", {31'd0, busy}, 1);
    rq0_req = 0;
    step();
    check("wr_we", {30'd0, mem_we, mem_re}, 32'b10);
    check("wr_addr", {24'd0, mem_addr}, 32'h12);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_done", {29'd0, rq0_done, rq0_err, rq1_done}, 32'b100);
    check("wr_busy_done", {31'd0, busy}, 0);
    step();

    // rq1 read 0x05, data at k=1
    rq1_req = 1; rq1_we = 0; rq1_addr = 8'h05;
    step();
    check("rd_gnt1", {30'd0, rq0_gnt, rq1_gnt}, 32'b01);
    rq1_req = 0;
    step();
    check("rd_re", {30'd0, mem_we, mem_re}, 32'b01);
    check("rd_addr", {24'd0, mem_addr}, 32'h05);
    step();
    check("rd_nodone_k1", {31'd0, rq1_done}, 0);
    mem_rdy = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rdy = 0; mem_rdata = '0;
    check("rd_done", {30'd0, rq1_done, rq1_err}, 32'b10);
    check("rd_rdata", rq1_rdata, 32'hCAFEF00D);
    check("rd_rq0_hold", {rq0_rdata[29:0], rq0_done, rq0_err}, 0);
    step();

    // both requesters contending with reads, data at k=0
    rq0_we = 0; rq1_we = 0; rq0_addr = 8'h20; rq1_addr = 8'h21;
    rq0_req = 1; rq1_req = 1; mem_rdy = 1; mem_rdata = 32'hA5A50001;
    n = 0; re0 = 0; re1 = 0; back2back = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (re0) begin rq0_req = 1; re0 = 0; end
      if (re1) begin rq1_req = 1; re1 = 0; end
      if (rq0_gnt) begin ord[n] = 0; n++; rq0_req = 0; end
      if (rq1_gnt) begin ord[n] = 1; n++; rq1_req = 0; end
      if (rq0_done) re0 = 1;
      if (rq1_done) re1 = 1;
    end
    check("rr_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n)) check($sformatf("rr_order%0d", i), ord[i], ord_exp[i]);
      if (i > 0 && i < int'(n) && ord[i] == ord[i-1]) back2back = 1;
    end
    check("rr_no_b2b", {31'd0, back2back}, 0);
    rq0_req = 0; rq1_req = 0;
    for (int c = 0; c < 10 && !rq1_done; c++) step();
    check("rr_last_done", {31'd0, rq1_done}, 1);
    check("rr_rdata1", rq1_rdata, 32'hA5A50001);
    mem_rdy = 0; mem_rdata = '0;
    step();

    // rq0 read timeout
    rq0_req = 1; rq0_addr = 8'h33;
    step();
    check("to_gnt0", {31'd0, rq0_gnt}, 1);
    rq0_req = 0;
    step(); step(); step(); step();
    check("to_nodone_t5", {30'd0, rq0_done, busy}, 32'b01);
    step();
    check("to_done", {30'd0, rq0_done, rq0_err}, 32'b11);
    check("to_rdata", rq0_rdata, 0);
    check("to_busy", {31'd0, busy}, 0);
    step();
    mem_rdy = 1; mem_rdata = 32'h77777777;
    step();
    mem_rdy = 0; mem_rdata = '0;
    check("late_ignored", {30'd0, rq0_done, busy}, 0);
    check("late_rdata", rq0_rdata, 0);
    rq1_req = 1; rq1_we = 1; rq1_addr = 8'h40; rq1_wdata = 32'h01020304;
    step();
    check("post_to_gnt1", {31'd0, rq1_gnt}, 1);
    rq1_req = 0;
    step();
    check("post_to_we", {30'd0, mem_we, rq1_done}, 32'b11);
    check("post_to_wdata", mem_wdata, 32'h01020304);
    check("post_to_err", {31'd0, rq1_err}, 0);
    step();

    // mem_rdy in the timeout cycle
    rq0_req = 1; rq0_we = 0; rq0_addr = 8'h34;
    step();
    rq0_req = 0;
    step(); step(); step(); step();
    mem_rdy = 1; mem_rdata = 32'h00000001;
    step();
    mem_rdy = 0; mem_rdata = '0;
    check("edge_done", {30'd0, rq0_done, rq0_err}, 32'b10);
    check("edge_rdata", rq0_rdata, 32'h00000001);
    step();

    // reset during WAIT
    rq1_req = 1; rq1_we = 0; rq1_addr = 8'h44;
    step();
    rq1_req = 0;
    step(); step();
    #2 arst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_strobes", {28'd0, rq1_gnt, rq1_done, mem_we, mem_re}, 0);
    check("mid_rst_addr", {24'd0, mem_addr}, 0);
    check("mid_rst_rdata", rq0_rdata | rq1_rdata, 0);
    step(); step();
    arst_n = 1'b1;
    step();
    check("post_rst_nodone", {29'd0, rq1_done, rq0_done, busy}, 0);
    rq0_req = 1; rq1_req = 1;
    step();
    check("post_rst_gnt", {30'd0, rq0_gnt, rq1_gnt}, 32'b10);
    rq0_req = 0; rq1_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
